// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
//   state_e    : controller states (IDLE, LOAD, CALC, DONE)
//   digit_e    : radix-4 Booth digit (0, +1, +2, -1, -2)
//   iter_count : number of radix-4 steps for an N-bit operand
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } digit_e;

  // Operands are extended to n+2 bits, so n/2+1 radix-4 digits cover them.
  function automatic int iter_count(input int n);
    return (n / 32'sd2) + 32'sd1;
  endfunction

endpackage

// File: rtl/booth_r4_mult_if.sv
// Start/Done level-handshake bundle of the Booth multiplier.
//   Start, Signed_mode, Mplier, Mcand : request side (driven by master)
//   Product, Done, Busy               : result side (driven by slave)
interface booth_r4_mult_if #(
  parameter int N = 8
);
  logic           Start;
  logic           Signed_mode;
  logic [N-1:0]   Mplier;
  logic [N-1:0]   Mcand;
  logic [2*N-1:0] Product;
  logic           Done;
  logic           Busy;

  modport master (
    output Start, Signed_mode, Mplier, Mcand,
    input  Product, Done, Busy
  );

  modport slave (
    input  Start, Signed_mode, Mplier, Mcand,
    output Product, Done, Busy
  );
endinterface

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder.
//   bits_i   : {q1, q0, q-1} of the shifting multiplier
//   mcand_i  : multiplicand already extended to N+2 bits
//   addend_o : selected 0 / +-Mcand / +-2Mcand, sign-extended to N+4 bits
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [2:0]   bits_i,
  input  logic [N+1:0] mcand_i,
  output logic [N+3:0] addend_o
);

  digit_e       digit_s;
  logic [N+3:0] ext_s;
  logic [N+3:0] dbl_s;

  assign ext_s = {{2{mcand_i[N+1]}}, mcand_i};
  assign dbl_s = {ext_s[N+2:0], 1'b0};

  // Map the overlapping bit triple to its Booth digit.
  always_comb begin
    digit_s = ZERO;
    case (bits_i)
      3'b000, 3'b111: digit_s = ZERO;
      3'b001, 3'b010: digit_s = P1;
      3'b011:         digit_s = P2;
      3'b100:         digit_s = M2;
      3'b101, 3'b110: digit_s = M1;
      default:        digit_s = ZERO;
    endcase
  end

  // Select the signed multiple of the multiplicand for this digit.
  always_comb begin
    addend_o = '0;
    case (digit_s)
      ZERO:    addend_o = '0;
      P1:      addend_o = ext_s;
      P2:      addend_o = dbl_s;
      M1:      addend_o = '0 - ext_s;
      M2:      addend_o = '0 - dbl_s;
      default: addend_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_mult.sv
// Parametrised radix-4 Booth sequential multiplier with Start/Done handshake.
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset; aborts any operation
//   bus    : slave side of booth_r4_mult_if
//            (Start, Signed_mode, Mplier, Mcand in; Product, Done, Busy out)
// One operation takes LOAD (1 cycle) + ITER CALC steps; Done rises ITER+1
// edges after Start is accepted and the registered Product is exact in 2N bits.
module booth_r4_mult
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  booth_r4_mult_if.slave   bus
);

  localparam int ITER = iter_count(N);
  localparam int W    = N + 2;          // extended operand width
  localparam int A    = N + 4;          // accumulator width, holds 2*Mcand
  localparam int T    = A + W + 1;      // {acc, Q, q-1}
  localparam int CW   = $clog2(ITER + 1);

  generate
    if (((N % 2) != 0) || (N < 4)) begin : g_bad_n
      $error("booth_r4_mult: N must be even and >= 4");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic             smode_q, smode_d;
  logic [W-1:0]     mcand_ext_q, mcand_ext_d;
  logic [A-1:0]     acc_q, acc_d;
  logic [W-1:0]     q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   product_q, product_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [A-1:0]     addend_s;
  logic [A-1:0]     sum_s;
  logic [T-1:0]     full_s;
  logic [T-1:0]     step_s;
  logic [A-1:0]     acc_n;
  logic [W-1:0]     q_n;
  logic             qm1_n;

  booth_r4_recoder #(.N(N)) u_recoder (
    .bits_i   ({q_q[1:0], qm1_q}),
    .mcand_i  (mcand_ext_q),
    .addend_o (addend_s)
  );

  // One radix-4 step: add the digit multiple, then arithmetic shift by two.
  assign sum_s  = acc_q + addend_s;
  assign full_s = {sum_s, q_q, qm1_q};
  assign step_s = {{2{sum_s[A-1]}}, full_s[T-1:2]};
  assign acc_n  = step_s[T-1 -: A];
  assign q_n    = step_s[W:1];
  assign qm1_n  = step_s[0];

  // Next-state, datapath and output decode.
  always_comb begin
    state_d     = state_q;
    mplier_d    = mplier_q;
    mcand_d     = mcand_q;
    smode_d     = smode_q;
    mcand_ext_d = mcand_ext_q;
    acc_d       = acc_q;
    q_d         = q_q;
    qm1_d       = qm1_q;
    cnt_d       = cnt_q;
    product_d   = product_q;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          mplier_d = bus.Mplier;
          mcand_d  = bus.Mcand;
          smode_d  = bus.Signed_mode;
          state_d  = LOAD;
        end else begin
          state_d  = IDLE;
        end
      end
      LOAD: begin
        if (smode_q) begin
          mcand_ext_d = {{2{mcand_q[N-1]}}, mcand_q};
          q_d         = {{2{mplier_q[N-1]}}, mplier_q};
        end else begin
          mcand_ext_d = {2'b00, mcand_q};
          q_d         = {2'b00, mplier_q};
        end
        acc_d   = '0;
        qm1_d   = 1'b0;
        cnt_d   = CW'(ITER);
        state_d = CALC;
      end
      CALC: begin
        acc_d = acc_n;
        q_d   = q_n;
        qm1_d = qm1_n;
        cnt_d = cnt_q - CW'(1'b1);
        if (cnt_q == CW'(1'b1)) begin
          // After ITER shifts the full product sits in {acc, Q}.
          product_d = {acc_n[N-3:0], q_n};
          state_d   = DONE;
        end else begin
          state_d   = CALC;
        end
      end
      DONE: begin
        if (!bus.Start) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == LOAD) || (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      mplier_q    <= '0;
      mcand_q     <= '0;
      smode_q     <= 1'b0;
      mcand_ext_q <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      qm1_q       <= 1'b0;
      cnt_q       <= '0;
      product_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mplier_q    <= mplier_d;
      mcand_q     <= mcand_d;
      smode_q     <= smode_d;
      mcand_ext_q <= mcand_ext_d;
      acc_q       <= acc_d;
      q_q         <= q_d;
      qm1_q       <= qm1_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.Product = product_q;
  assign bus.Done    = done_q;
  assign bus.Busy    = busy_q;

endmodule
